// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active low (0 = segment lit).
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF = 7'h7F;

    localparam seg7_t SEG_0 = 7'b1000000;
    localparam seg7_t SEG_1 = 7'b1111001;
    localparam seg7_t SEG_2 = 7'b0100100;
    localparam seg7_t SEG_3 = 7'b0110000;
    localparam seg7_t SEG_4 = 7'b0011001;
    localparam seg7_t SEG_5 = 7'b0010010;
    localparam seg7_t SEG_6 = 7'b0000010;
    localparam seg7_t SEG_7 = 7'b1111000;
    localparam seg7_t SEG_8 = 7'b0000000;
    localparam seg7_t SEG_9 = 7'b0010000;
    localparam seg7_t SEG_A = 7'b0001000;
    localparam seg7_t SEG_B = 7'b0000011;
    localparam seg7_t SEG_C = 7'b1000110;
    localparam seg7_t SEG_D = 7'b0100001;
    localparam seg7_t SEG_E = 7'b0000110;
    localparam seg7_t SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the datapath/debug registers and the scan driver.
// master = register side driving display data; slave = the driver.
interface seg7_scan_driver_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic                    load_i;
    logic                    blank_i;
    seg7_t                   seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    frame_o;

    modport master (
        output value_i, dp_i, load_i, blank_i,
        input  seg_o, dp_o, an_o, frame_o
    );

    modport slave (
        input  value_i, dp_i, load_i, blank_i,
        output seg_o, dp_o, an_o, frame_o
    );
endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg7_t      seg_o
);

    // Full 16-entry table; every code is covered explicitly.
    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver for NUM_DIGITS hex digits.
// Each digit owns a slot of REFRESH_DIV cycles; the first BLANK_CYCLES of a
// slot keep every anode off to avoid ghosting. New values are staged in a
// pending register and committed only at the frame wrap so a frame never
// mixes old and new digits.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        pre_cnt;
    logic [IDX_W-1:0]        dig_idx;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_vld;

    logic                    slot_end;
    logic                    frame_wrap;
    logic [3:0]              cur_nib;
    seg7_t                   seg_dec;
    logic                    show_dig;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_sel;

    seg7_t                   seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_q;

    assign slot_end   = (pre_cnt == PRE_LAST);
    assign frame_wrap = slot_end && (dig_idx == IDX_LAST);
    assign cur_nib    = disp_val[{dig_idx, 2'b00} +: 4];

    seg7_hex_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (seg_dec)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_idx;

    // Highest nonzero digit; digit 0 is always shown so an all-zero value reads "0".
    always_comb begin
        msd_idx = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (disp_val[4*k +: 4] != 4'h0) begin
                msd_idx = IDX_W'(k);
            end
        end
    end

    assign show_dig = (dig_idx <= msd_idx);
`else
    assign show_dig = 1'b1;
`endif

    assign lit = (pre_cnt >= PRE_BLANK) && !bus.blank_i && show_dig;

    // One-hot active-low anode select for the current slot.
    always_comb begin
        an_sel          = '1;
        an_sel[dig_idx] = 1'b0;
    end

    // Prescaler and round-robin digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            dig_idx <= '0;
        end else if (slot_end) begin
            pre_cnt <= '0;
            dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Staged load with commit at frame wrap; a load on the wrap itself bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
        end else if (bus.load_i && frame_wrap) begin
            disp_val <= bus.value_i;
            disp_dp  <= bus.dp_i;
            pend_vld <= 1'b0;
        end else begin
            if (frame_wrap && pend_vld) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                pend_vld <= 1'b0;
            end
            if (bus.load_i) begin
                pend_val <= bus.value_i;
                pend_dp  <= bus.dp_i;
                pend_vld <= 1'b1;
            end
        end
    end

    // Registered outputs; segments and dp are forced dark whenever the anode is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_wrap;
            if (lit) begin
                seg_q <= seg_dec;
                dp_q  <= ~disp_dp[dig_idx];
                an_q  <= an_sel;
            end else begin
                seg_q <= SEG_OFF;
                dp_q  <= 1'b1;
                an_q  <= '1;
            end
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = dp_q;
    assign bus.an_o    = an_q;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed steps plus random traffic, every cycle
// compared against a cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int ND  = 4;
    localparam int RD  = 4;
    localparam int BC  = 1;
    localparam int FRM = RD * ND;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: n = clock edges since reset release.
    int          n;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    bit          m_vld;

    task automatic model_reset();
        n = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_vld = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [15:0] v, input logic [3:0] d, input bit ld, input bit bl);
        int pre, idx, nib, msd;
        bit wrap, show, lit;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic e_dp;
        bus.value_i = v; bus.dp_i = d; bus.load_i = ld; bus.blank_i = bl;
        pre  = n % RD;
        idx  = (n / RD) % ND;
        wrap = (n % FRM) == FRM - 1;
        nib  = int'((m_disp >> (4 * idx)) & 16'hF);
        msd  = 0;
        for (int k = 0; k < ND; k++) if (((m_disp >> (4 * k)) & 16'hF) != 0) msd = k;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        show = idx <= msd;
`else
        show = 1;
`endif
        lit   = (pre >= BC) && !bl && show;
        e_seg = lit ? lut[nib] : 7'h7F;
        e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
        e_dp  = lit ? ~m_dp[idx] : 1'b1;
        @(posedge clk);
        #1;
        chk("seg_o",   16'(bus.seg_o),   16'(e_seg));
        chk("an_o",    16'(bus.an_o),    16'(e_an));
        chk("dp_o",    16'(bus.dp_o),    16'(e_dp));
        chk("frame_o", 16'(bus.frame_o), 16'(wrap));
        if (ld && wrap) begin
            m_disp = v; m_dp = d; m_vld = 0;
        end else begin
            if (wrap && m_vld) begin m_disp = m_pend; m_dp = m_pdp; m_vld = 0; end
            if (ld) begin m_pend = v; m_pdp = d; m_vld = 1; end
        end
        n++;
    endtask

    task automatic idle(input int cyc, input bit bl);
        for (int i = 0; i < cyc; i++) step(16'($urandom), 4'($urandom), 0, bl);
    endtask

    task automatic to_phase(input int ph);
        for (int i = 0; i < FRM && (n % FRM) != ph; i++) idle(1, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_seg"},   16'(bus.seg_o),   16'h7F);
        chk({tag, "_an"},    16'(bus.an_o),    16'hF);
        chk({tag, "_dp"},    16'(bus.dp_o),    16'h1);
        chk({tag, "_frame"}, 16'(bus.frame_o), 16'h0);
    endtask

    initial begin
        bus.value_i = '0; bus.dp_i = '0; bus.load_i = 0; bus.blank_i = 0;
        model_reset();

        // Reset held with traffic on all inputs.
        for (int i = 0; i < 4; i++) begin
            bus.value_i = 16'($urandom); bus.dp_i = 4'($urandom);
            bus.load_i = 1'($urandom); bus.blank_i = 1'($urandom);
            @(posedge clk);
            #1;
            chk_reset_outs("rst_hold");
        end
        rst_n = 1'b1;

        // Scan pattern of all-zero display over two frames.
        idle(2 * FRM, 0);

        // Decode example, loaded mid-frame.
        to_phase(5);
        step(16'hA5C0, 4'b0000, 1, 0);
        idle(2 * FRM, 0);

        // Sweep all 16 nibbles.
        step(16'h3210, 4'b0000, 1, 0); idle(2 * FRM, 0);
        step(16'h7654, 4'b0000, 1, 0); idle(2 * FRM, 0);
        step(16'hBA98, 4'b0000, 1, 0); idle(2 * FRM, 0);
        step(16'hFEDC, 4'b0000, 1, 0); idle(2 * FRM, 0);

        // Tear-free mid-frame load, back-to-back loads (last wins).
        to_phase(3);
        step(16'h9999, 4'b1111, 1, 0);
        step(16'h1234, 4'b0000, 1, 0);
        idle(2 * FRM, 0);

        // Load coincident with frame wrap goes straight to display.
        to_phase(FRM - 1);
        step(16'h5678, 4'b0000, 1, 0);
        idle(2 * FRM, 0);

        // Decimal point on digit 2, then blanking.
        step(16'h4321, 4'b0100, 1, 0);
        idle(2 * FRM, 0);
        idle(FRM + 3, 1);
        idle(FRM, 0);

        // Leading-zero values.
        step(16'h0070, 4'b0011, 1, 0); idle(2 * FRM, 0);
        step(16'h0000, 4'b0001, 1, 0); idle(2 * FRM, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(16'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));

        // Async reset mid-slot (pre_cnt=2, dig_idx=2) with a load pending.
        to_phase(1);
        step(16'h1234, 4'b1111, 1, 0);
        to_phase(2 * RD + 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("async_rst");
        #1 rst_n = 1'b1;
        model_reset();
        idle(2 * FRM, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed 7-segment display driver for NUM_DIGITS hex digits sharing one segment bus.
- Scans digits round-robin at a programmable refresh rate.
- Decodes full hex 0-F and drives active-low segment, decimal-point and anode lines.
- Loads new values tear-free, committing them only at frame boundaries.
- Inserts a per-slot anode-off gap against ghosting.
- Sits between the datapath/debug registers and the board's common-anode display.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (legal 1..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (0..REFRESH_DIV-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value_i  in  4*NUM_DIGITS  hex nibbles; digit k = value_i[4k+3:4k], digit 0 rightmost
dp_i  in  NUM_DIGITS  decimal point request per digit, 1 = lit
load_i  in  1  one-cycle strobe capturing value_i/dp_i
blank_i  in  1  level; 1 = whole display dark
seg_o  out  7  segments {g,f,e,d,c,b,a}, active low
dp_o  out  1  decimal point, active low
an_o  out  NUM_DIGITS  digit anodes, active low
frame_o  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset state:
  - Outputs: seg_o=7'h7F, dp_o=1, an_o all ones, frame_o=0.
  - Internal: pre_cnt=0, dig_idx=0, disp/pend registers=0, pend_vld=0.
- Prescaler: pre_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap cycle, dig_idx advances modulo NUM_DIGITS.
  - NUM_DIGITS=1: dig_idx stays 0 and every slot is a frame wrap.
- Frame wrap: cycle where pre_cnt=REFRESH_DIV-1 and dig_idx=NUM_DIGITS-1.
- Load:
  - load_i=1 captures value_i/dp_i into pend and sets pend_vld.
  - At frame wrap with pend_vld=1: disp <= pend, pend_vld cleared.
  - load_i coinciding with frame wrap: value_i/dp_i go straight to disp and pend_vld=0 (bypass).
  - Back-to-back loads within a frame: last one wins.
- Output stage (all outputs registered, one cycle after the pre_cnt/dig_idx state they reflect):
  - an_o[dig_idx]=0 only when pre_cnt>=BLANK_CYCLES and blank_i=0; all other anodes 1.
  - seg_o = decode(disp nibble dig_idx); dp_o = ~disp_dp[dig_idx].
  - Both forced to off (7'h7F / 1) whenever the anode is off.
  - frame_o=1 for exactly the cycle after the frame wrap.
- Decode table, active low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - All 16 codes defined; no latch, no default gap.
- blank_i:
  - Takes effect on the next registered output.
  - Scanning and loading continue while blanked.
- Reset mid-scan: immediate return to reset state; any pending load is lost.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant nonzero disp nibble keep their anode off for their whole slot. Digit 0 is always shown, so value 0 shows a single "0". The dp of a suppressed digit is also suppressed.
- Undefined: every digit is displayed, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - SEG_OFF=7'h7F and the 16 decode constants.
  - Function or typedef for the 7-bit segment vector.
- Sub-module seg7_hex_dec: purely combinational 4-bit to 7-bit active-low decoder, instantiated once on the muxed nibble.
- Top level owns the prescaler, scan counter, load/commit registers and output registers.

Test Plan:
- Reset release: hold rst_n=0 with traffic on inputs -> seg_o=7F, an_o=F, dp_o=1, frame_o=0. Then REFRESH_DIV=4, BLANK_CYCLES=1: an_o cycles E,D,B,7 with 1 dark cycle/slot, and frame_o pulses every 16 cycles.
- Decode: load value_i=16'hA5C0 -> after next frame_o, slots show seg 1000000, 1000110, 0010010, 0001000 on digits 0..3. Sweep all 16 nibbles against the table.
- Tear-free load: load 16'h1234 mid-frame -> old value persists until frame_o. Load coincident with frame wrap -> new value in the very next frame, pend_vld=0.
- Blank and dp: dp_i=4'b0100 -> dp_o=0 only in digit 2's lit cycles. blank_i=1 -> an_o=F, seg_o=7F next cycle while frame_o keeps pulsing.
- Async reset mid-slot: rst_n low at pre_cnt=2, dig_idx=2 -> outputs reset within the same cycle; pending load discarded.
- With SEG7_LEADING_ZERO_BLANK_EN: value 16'h0070 -> digits 2,3 never lit, digits 0,1 lit. Value 16'h0000 -> only digit 0 lit, showing 1000000.
